rr_sample_arbiter: RTL and testbench

- Round-robin arbiter sharing one registered sample path (output register plus valid/ready handshake) among NUM_REQ requesters.
- Grants one owner at a time for a burst of up to MAX_BURST words, then rotates priority.
- Sits between multiple producer blocks and a single downstream register consumer in the same clock domain.

---
 rtl/rr_sample_arbiter_pkg.sv | 34 +++
 rtl/rr_sample_arbiter_if.sv | 44 ++++
 rtl/rr_sample_arbiter_pick.sv | 37 +++
 rtl/rr_sample_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_sample_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_sample_arbiter_pkg.sv
// Shared definitions for the round-robin sample arbiter: default sizing,
// the controller state encoding and small width helpers.
package rr_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 10;
    localparam int DEF_MAX_BURST = 4;

    // Controller states. The top keeps the register as plain logic and
    // compares against localparam copies of these values.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Width of an index into a vector of 'value' entries, never below 1.
    function automatic int idx_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/rr_sample_arbiter_if.sv
// Bundle of requester-side and consumer-side signals around the arbiter.
// master: the surrounding system (producers + downstream consumer).
// slave : the arbiter itself.
interface rr_sample_arbiter_if #(
    parameter int NUM_REQ = rr_arb_pkg::DEF_NUM_REQ,
    parameter int DATA_W  = rr_arb_pkg::DEF_DATA_W,
    parameter int SRC_W   = rr_arb_pkg::idx_width(NUM_REQ)
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        accept;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
    logic                      busy;

    modport master (
        output req,
        output req_data,
        output out_ready,
        input  grant,
        input  accept,
        input  out_valid,
        input  out_data,
        input  out_src,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data,
        input  out_ready,
        output grant,
        output accept,
        output out_valid,
        output out_data,
        output out_src,
        output busy
    );

endinterface

// File: rtl/rr_sample_arbiter_pick.sv
// Combinational round-robin picker. Returns the first set request at or
// above rr_ptr, wrapping modulo NUM_REQ. The request vector is doubled and
// shifted down by rr_ptr so a plain lowest-bit priority encode finds the
// winner's offset from the pointer.
module rr_pick #(
    parameter int NUM_REQ = rr_arb_pkg::DEF_NUM_REQ,
    parameter int SRC_W   = rr_arb_pkg::idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic               any_req,
    output logic [SRC_W-1:0]   owner
);

    logic [NUM_REQ-1:0] window;
    logic [SRC_W-1:0]   offset;
    logic [SRC_W:0]     sum;

    // Rotate requests so the pointer position sits at bit 0, then encode.
    always_comb begin
        window  = NUM_REQ'({req, req} >> rr_ptr);
        any_req = |req;
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (window[i]) begin
                offset = SRC_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (SRC_W + 1)'(NUM_REQ)) begin
            owner = SRC_W'(sum - (SRC_W + 1)'(NUM_REQ));
        end else begin
            owner = SRC_W'(sum);
        end
    end

endmodule

// File: rtl/rr_sample_arbiter.sv
// Round-robin arbiter sharing one registered sample path among NUM_REQ
// producers. One owner at a time moves up to MAX_BURST words through the
// output register, then priority rotates to the next requester.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; pick next requester from rr_ptr, grant next cycle
//   OWN   | owner holds grant; words move when output register can take one
//
// Exactly one IDLE cycle separates consecutive grants. Release never
// touches the output register, so a stalled final word waits for the
// consumer while arbitration continues.
module rr_sample_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic              clock,
    input logic              reset,
    rr_sample_arbiter_if.slave bus
);

    localparam int SRC_W = idx_width(NUM_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_OWN  = OWN;

    logic [0:0]         state;
    logic [SRC_W-1:0]   owner;
    logic [SRC_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant_q;
    logic [CNT_W-1:0]   burst_cnt;
    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic [SRC_W-1:0]   out_src_q;

    logic               pick_any;
    logic [SRC_W-1:0]   pick_owner;
    logic               owner_req;
    logic [DATA_W-1:0]  owner_data;
    logic               xfer;
    logic               last_xfer;
    logic               release_own;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req     (bus.req),
        .rr_ptr  (rr_ptr),
        .any_req (pick_any),
        .owner   (pick_owner)
    );

    // Transfer and release conditions for the current owner. Reset masks
    // the transfer so nothing is reported as taken in a cycle that is
    // about to be discarded.
    always_comb begin
        owner_req   = bus.req[owner];
        owner_data  = bus.req_data[int'(owner) * DATA_W +: DATA_W];
        xfer        = !reset && (state == ST_OWN) && owner_req
                      && (!out_valid_q || bus.out_ready);
        last_xfer   = xfer && (burst_cnt == CNT_W'(MAX_BURST - 1));
        release_own = (state == ST_OWN) && (!owner_req || last_xfer);
    end

    // Arbitration FSM: ownership, grant, burst counting and pointer rotation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            grant_q   <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_owner;
                        grant_q   <= NUM_REQ'(1) << pick_owner;
                        burst_cnt <= '0;
                        state     <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (release_own) begin
                        state     <= ST_IDLE;
                        grant_q   <= '0;
                        burst_cnt <= '0;
                        rr_ptr    <= (owner == SRC_W'(NUM_REQ - 1)) ? '0
                                                                    : owner + 1'b1;
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Output register: load on transfer, empty when consumed with no refill.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= owner_data;
            out_src_q   <= owner;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.accept    = xfer ? (NUM_REQ'(1) << owner) : '0;
    assign bus.grant     = grant_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.busy      = (state == ST_OWN);

endmodule

// File: tb/tb_rr_sample_arbiter.sv
// Bench for rr_sample_arbiter: producer queues drive requests, a
// round-robin reference model predicts grant/accept/valid each cycle and
// queues the expected words; a separate monitor checks every consumed word.
module tb_rr_sample_arbiter;
    import rr_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 10;
    localparam int B = 4;
    localparam int S = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rr_sample_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus();

    rr_sample_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (W),
        .MAX_BURST (B)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // producer word queues (circular)
    logic [W-1:0] pbuf [N][256];
    int           phead [N];
    int           pcnt  [N];

    // scoreboard of expected {src, data}
    logic [S+W-1:0] sb [$];

    // reference model state
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_words = 0;
    bit   m_full  = 1'b0;
    logic rdy     = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_word(input int i);
        if (pcnt[i] < 250) begin
            pbuf[i][(phead[i] + pcnt[i]) % 256] = W'($urandom);
            pcnt[i]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req[i]              = (pcnt[i] > 0);
            bus.req_data[i*W +: W]  = pbuf[i][phead[i]];
        end
        bus.out_ready = rdy;
    endtask

    function automatic int rr_search();
        for (int k = 0; k < N; k++) begin
            if (pcnt[(m_ptr + k) % N] > 0) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_words = 0;
        m_full  = 1'b0;
        sb.delete();
    endtask

    // Called at the falling edge: check the visible state, then advance the
    // model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_acc;
        bit           owner_has;
        bit           acc;
        int           nxt;
        exp_grant = '0;
        exp_acc   = '0;
        owner_has = 1'b0;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            owner_has = (pcnt[m_owner] > 0);
        end
        acc = (m_owner >= 0) && owner_has && (!m_full || rdy);
        if (acc) exp_acc[m_owner] = 1'b1;

        chk("grant", int'(bus.grant), int'(exp_grant));
        chk("accept", int'(bus.accept), int'(exp_acc));
        chk("out_valid", int'(bus.out_valid), int'(m_full));
        chk("busy", int'(bus.busy), (m_owner >= 0) ? 1 : 0);

        if (acc) begin
            sb.push_back({S'(m_owner), pbuf[m_owner][phead[m_owner]]});
            phead[m_owner] = (phead[m_owner] + 1) % 256;
            pcnt[m_owner]--;
            m_words++;
            m_full = 1'b1;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end

        if (m_owner < 0) begin
            nxt = rr_search();
            if (nxt >= 0) begin
                m_owner = nxt;
                m_words = 0;
            end
        end else if (!owner_has || (acc && m_words == B)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_words = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        drive();
        @(negedge clock);
        model_step();
    endtask

    // Hold reset for n rising edges, checking cleared outputs after the first.
    task automatic do_reset(input int n, input bit with_req);
        @(posedge clock);
        #1;
        reset = 1'b1;
        if (with_req) begin
            for (int i = 0; i < N; i++) if (pcnt[i] == 0) add_word(i);
        end
        drive();
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(posedge clock);
            @(negedge clock);
            chk("rst_accept", int'(bus.accept), 0);
            if (k > 0) begin
                chk("rst_grant", int'(bus.grant), 0);
                chk("rst_out_valid", int'(bus.out_valid), 0);
                chk("rst_out_data", int'(bus.out_data), 0);
                chk("rst_out_src", int'(bus.out_src), 0);
                chk("rst_busy", int'(bus.busy), 0);
            end
        end
        reset = 1'b0;
        model_reset();
        drive();
        model_step();
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (pcnt[i] != 0) return 1'b0;
        return (sb.size() == 0) && (m_owner < 0) && !m_full;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        rdy = 1'b1;
        while (!all_done() && n < budget) begin
            cycle();
            n++;
        end
        if (!all_done()) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    // Monitor: every consumed word must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && bus.out_valid && bus.out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL out_word: got src=%0d data=%h, expected nothing", bus.out_src, bus.out_data);
                end else begin
                    logic [S+W-1:0] e;
                    e = sb.pop_front();
                    if ({bus.out_src, bus.out_data} !== e) begin
                        bad++;
                        $display("FAIL out_word: got src=%0d data=%h expected src=%0d data=%h",
                                 bus.out_src, bus.out_data, e[S+W-1:W], e[W-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] held;
        for (int i = 0; i < N; i++) begin
            phead[i] = 0;
            pcnt[i]  = 0;
        end
        drive();

        // reset with every requester active; first grant goes to 0
        do_reset(2, 1'b1);
        drain(200);

        // lone requester 2 with six words: burst of 4, bubble, regrant, 2
        for (int k = 0; k < 6; k++) add_word(2);
        drain(200);

        // all four busy from pointer 0: rotation 0,1,2,3,0
        do_reset(2, 1'b0);
        for (int i = 0; i < N; i++) for (int k = 0; k < 8; k++) add_word(i);
        drain(300);

        // backpressure after the first word
        do_reset(2, 1'b0);
        for (int k = 0; k < 6; k++) add_word(0);
        rdy = 1'b1;
        n = 0;
        while (!m_full && n < 20) begin
            cycle();
            n++;
        end
        rdy = 1'b0;
        held = sb[0][W-1:0];
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_data", int'(bus.out_data), int'(held));
            chk("stall_src", int'(bus.out_src), 0);
        end
        drain(200);

        // early drop: owner 1 leaves after two words, requester 3 next
        do_reset(2, 1'b0);
        add_word(1);
        add_word(1);
        for (int k = 0; k < 4; k++) add_word(3);
        drain(200);

        // reset in the middle of owner 0's burst
        do_reset(2, 1'b0);
        for (int k = 0; k < 4; k++) add_word(0);
        rdy = 1'b1;
        n = 0;
        while (!(m_owner == 0 && m_words == 2) && n < 20) begin
            cycle();
            n++;
        end
        rdy = 1'b0;
        do_reset(1, 1'b0);
        for (int k = 0; k < 4; k++) add_word(0);
        drain(200);

        // random traffic and random consumer stalls
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) add_word(i);
            rdy = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain(2000);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
